// File: rtl/rete.sv
// rtl/rete.sv - two-register ALU datapath (A/B registers, 2:1 muxes, add/sub ALU)

module rete_reg #(
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);
  logic [N-1:0] data_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;
endmodule

module rete_mux2 #(
  parameter int unsigned N = 8
) (
  input  logic         sel_i,
  input  logic [N-1:0] in0_i,
  input  logic [N-1:0] in1_i,
  output logic [N-1:0] out_o
);
  assign out_o = sel_i ? in1_i : in0_i;
endmodule

module rete_alu #(
  parameter int unsigned N = 8
) (
  input  logic         sub_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] r_o
);
  // Carry/borrow dropped on purpose: results wrap modulo 2^N.
  assign r_o = sub_i ? (a_i - b_i) : (a_i + b_i);
endmodule

module rete #(
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         rst_n,
  output logic [N-1:0] out,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         mux1,
  input  logic         mux2,
  input  logic         wea,
  input  logic         web,
  input  logic         aluctl
);
  logic [N-1:0] a_val;
  logic [N-1:0] b_val;
  logic [N-1:0] alu_r;
  logic [N-1:0] a_d;
  logic [N-1:0] b_d;

  rete_alu #(.N(N)) u_alu (
    .sub_i (aluctl),
    .a_i   (a_val),
    .b_i   (b_val),
    .r_o   (alu_r)
  );

  rete_mux2 #(.N(N)) u_mux_a (
    .sel_i (mux1),
    .in0_i (x),
    .in1_i (alu_r),
    .out_o (a_d)
  );

  rete_mux2 #(.N(N)) u_mux_b (
    .sel_i (mux2),
    .in0_i (y),
    .in1_i (alu_r),
    .out_o (b_d)
  );

  rete_reg #(.N(N)) u_reg_a (
    .clock (clock),
    .rst_n (rst_n),
    .en_i  (wea),
    .d_i   (a_d),
    .q_o   (a_val)
  );

  rete_reg #(.N(N)) u_reg_b (
    .clock (clock),
    .rst_n (rst_n),
    .en_i  (web),
    .d_i   (b_d),
    .q_o   (b_val)
  );

  assign out = alu_r;
endmodule

// File: tb/tb_rete.sv
// tb/tb_rete.sv - vector table, corner sequences and random model checks for rete

module tb_rete;
  localparam int N = 8;

  logic         clock;
  logic         rst_n;
  logic [N-1:0] out;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         mux1;
  logic         mux2;
  logic         wea;
  logic         web;
  logic         aluctl;

  int total;
  int bad;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         mux1;
    logic         mux2;
    logic         wea;
    logic         web;
    logic         aluctl;
    logic [N-1:0] exp_out;
  } vec_t;

  vec_t vecs[12];

  rete #(.N(N)) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .out    (out),
    .x      (x),
    .y      (y),
    .mux1   (mux1),
    .mux2   (mux2),
    .wea    (wea),
    .web    (web),
    .aluctl (aluctl)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic edge_settle();
    @(posedge clock);
    #1;
  endtask

  function automatic int alu_ref(int a, int b, bit sub);
    return sub ? ((a - b) % 256 + 256) % 256 : (a + b) % 256;
  endfunction

  task automatic set_vec(input vec_t v);
    x = v.x; y = v.y; mux1 = v.mux1; mux2 = v.mux2;
    wea = v.wea; web = v.web; aluctl = v.aluctl;
  endtask

  initial begin
    int ma, mb, r;
    total = 0;
    bad   = 0;

    // x, y, mux1, mux2, wea, web, aluctl, expected out after the edge
    vecs[0]  = '{8'd8,   8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8};
    vecs[1]  = '{8'd99,  8'd99,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd8};
    vecs[2]  = '{8'd0,   8'd7,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd15};
    vecs[3]  = '{8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd23};
    vecs[4]  = '{8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd31};
    vecs[5]  = '{8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd39};
    vecs[6]  = '{8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd47};
    vecs[7]  = '{8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd55};
    vecs[8]  = '{8'd200, 8'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd44};
    vecs[9]  = '{8'd7,   8'd8,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd255};
    vecs[10] = '{8'd0,   8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd247};
    vecs[11] = '{8'd0,   8'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd14};

    // Reset held with enables active: nothing may load.
    rst_n = 1'b0;
    x = 8'd8; y = 8'd7; mux1 = 1'b0; mux2 = 1'b0; wea = 1'b1; web = 1'b1; aluctl = 1'b0;
    #1;
    check("reset_async", out, 8'd0);
    for (int i = 0; i < 3; i++) begin
      edge_settle();
      check("reset_hold", out, 8'd0);
    end
    wea = 1'b0; web = 1'b0;
    rst_n = 1'b1;
    edge_settle();
    check("reset_release", out, 8'd0);

    for (int i = 0; i < 12; i++) begin
      set_vec(vecs[i]);
      edge_settle();
      check($sformatf("vec%0d", i), out, vecs[i].exp_out);
    end

    // A=7,B=7 from the table; load A=8,B=7 and flip aluctl without an edge.
    x = 8'd8; y = 8'd7; mux1 = 1'b0; mux2 = 1'b0; wea = 1'b1; web = 1'b1; aluctl = 1'b0;
    edge_settle();
    check("load_ab_add", out, 8'd15);
    wea = 1'b0; web = 1'b0; aluctl = 1'b1;
    #1;
    check("comb_sub", out, 8'd1);

    // Reset mid-accumulate, between edges.
    aluctl = 1'b0; mux2 = 1'b1; web = 1'b1;
    edge_settle();
    check("acc_before_rst", out, 8'd23);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    check("rst_mid_acc", out, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_settle();
      check("acc_after_rst", out, 8'd0);
    end

    // Random traffic against the arithmetic model.
    ma = 0; mb = 0;
    for (int i = 0; i < 300; i++) begin
      x = N'($urandom); y = N'($urandom);
      mux1 = 1'($urandom); mux2 = 1'($urandom);
      wea = 1'($urandom); web = 1'($urandom); aluctl = 1'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_rst", out, 8'd0);
        rst_n = 1'b1;
        ma = 0; mb = 0;
      end
      #1;
      check("rand_comb", out, N'(alu_ref(ma, mb, aluctl)));
      r = alu_ref(ma, mb, aluctl);
      edge_settle();
      if (wea) ma = mux1 ? r : int'(x);
      if (web) mb = mux2 ? r : int'(y);
      check("rand_edge", out, N'(alu_ref(ma, mb, aluctl)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
